// File: rtl/door_access_ctrl_if.sv
// Switch/button inputs and status outputs of the passcode entry stage.
// master = stimulus/door side, slave = door_access_ctrl.
interface door_access_ctrl_if;
   logic [3:0] digit;
   logic       enter;
   logic       door_cycle_complete;
   logic       open_btn;
   logic       locked;
   logic       attempt_fail;
   logic [2:0] digit_count;
   logic [7:0] lock_remaining;

   modport master (
      output digit, enter, door_cycle_complete,
      input  open_btn, locked, attempt_fail, digit_count, lock_remaining
   );

   modport slave (
      input  digit, enter, door_cycle_complete,
      output open_btn, locked, attempt_fail, digit_count, lock_remaining
   );
endinterface

// File: rtl/door_access_ctrl.sv
// Passcode entry: collects CODE_LEN digits on enter presses, opens the door on a
// match, and locks out entry for LOCK_CYCLES after MAX_FAILS consecutive misses.
module door_access_ctrl #(
   parameter int unsigned              CODE_LEN    = 4,
   parameter logic [4*CODE_LEN-1:0]    CODE        = 16'h1234,
   parameter int unsigned              MAX_FAILS   = 3,
   parameter int unsigned              LOCK_CYCLES = 20
) (
   input logic                clk_slow,
   input logic                rst_a_p,
   door_access_ctrl_if.slave  bus
);

   localparam int unsigned CODE_W  = 4 * CODE_LEN;
   localparam int unsigned COUNT_W = 3;
   localparam int unsigned REM_W   = 8;

   typedef enum logic [1:0] {IDLE, CHECK, OPEN_WAIT, LOCKOUT} state_t;

   state_t              state, state_d;
   logic [CODE_W-1:0]   code_buf, code_buf_d;
   logic [COUNT_W-1:0]  fail_cnt, fail_cnt_d;
   logic [COUNT_W-1:0]  count_d;
   logic [REM_W-1:0]    remain_d;
   logic                open_d, locked_d, fail_pulse_d;
   logic                enter_q;
   logic                press_c;

   assign press_c = bus.enter & ~enter_q;

   // State and registered outputs; enter_q resets high so a held button is not a press.
   always_ff @(posedge clk_slow or posedge rst_a_p) begin
      if (rst_a_p) begin
         state              <= IDLE;
         code_buf           <= '0;
         fail_cnt           <= '0;
         enter_q            <= 1'b1;
         bus.open_btn       <= 1'b0;
         bus.locked         <= 1'b0;
         bus.attempt_fail   <= 1'b0;
         bus.digit_count    <= '0;
         bus.lock_remaining <= '0;
      end else begin
         state              <= state_d;
         code_buf           <= code_buf_d;
         fail_cnt           <= fail_cnt_d;
         enter_q            <= bus.enter;
         bus.open_btn       <= open_d;
         bus.locked         <= locked_d;
         bus.attempt_fail   <= fail_pulse_d;
         bus.digit_count    <= count_d;
         bus.lock_remaining <= remain_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state;
      code_buf_d   = code_buf;
      fail_cnt_d   = fail_cnt;
      open_d       = bus.open_btn;
      locked_d     = bus.locked;
      fail_pulse_d = 1'b0;
      count_d      = bus.digit_count;
      remain_d     = bus.lock_remaining;

      unique case (state)
         IDLE: begin
            if (press_c) begin
               code_buf_d = CODE_W'({code_buf, bus.digit});
               count_d    = bus.digit_count + COUNT_W'(1);
               if (bus.digit_count == COUNT_W'(CODE_LEN - 1)) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            count_d = '0;
            if (code_buf == CODE) begin
               state_d    = OPEN_WAIT;
               open_d     = 1'b1;
               fail_cnt_d = '0;
            end else begin
               fail_pulse_d = 1'b1;
               fail_cnt_d   = fail_cnt + COUNT_W'(1);
               if (fail_cnt_d == COUNT_W'(MAX_FAILS)) begin
                  state_d  = LOCKOUT;
                  locked_d = 1'b1;
                  remain_d = REM_W'(LOCK_CYCLES);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OPEN_WAIT: begin
            // Drop the request on the completion edge so the door never re-triggers.
            if (bus.door_cycle_complete) begin
               open_d  = 1'b0;
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (bus.lock_remaining == REM_W'(1)) begin
               remain_d   = '0;
               locked_d   = 1'b0;
               fail_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               remain_d = bus.lock_remaining - REM_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl with hand-computed expectations.
module tb_door_access_ctrl;

   logic clk_slow = 1'b0;
   logic rst_a_p  = 1'b1;
   int   errors   = 0;
   int   checks   = 0;

   door_access_ctrl_if bus ();

   door_access_ctrl #(
      .CODE_LEN   (4),
      .CODE       (16'h1234),
      .MAX_FAILS  (3),
      .LOCK_CYCLES(20)
   ) dut (
      .clk_slow(clk_slow),
      .rst_a_p (rst_a_p),
      .bus     (bus.slave)
   );

   always #5 clk_slow = ~clk_slow;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic step();
      @(posedge clk_slow);
      #1;
   endtask

   // One-cycle enter pulse followed by one low cycle.
   task automatic press(input logic [3:0] d, input int exp_cnt);
      bus.digit = d;
      bus.enter = 1'b1;
      step();
      check("digit_count", 32'(bus.digit_count), 32'(exp_cnt));
      check("open_during_entry", 32'(bus.open_btn), 0);
      bus.enter = 1'b0;
      step();
   endtask

   // Enters four digits; returns two edges after the final press.
   task automatic enter_code(input logic [15:0] c);
      logic [3:0] d;
      for (int i = 0; i < 4; i++) begin
         d = c[15-4*i -: 4];
         press(d, i + 1);
      end
   endtask

   task automatic expect_open_then_close();
      check("open_btn_rise", 32'(bus.open_btn), 1);
      check("count_cleared", 32'(bus.digit_count), 0);
      repeat (9) step();
      check("open_btn_held", 32'(bus.open_btn), 1);
      bus.door_cycle_complete = 1'b1;
      step();
      check("open_btn_fall", 32'(bus.open_btn), 0);
      bus.door_cycle_complete = 1'b0;
      step();
      check("open_btn_stays_low", 32'(bus.open_btn), 0);
   endtask

   task automatic expect_wrong(input logic exp_locked);
      check("attempt_fail_pulse", 32'(bus.attempt_fail), 1);
      check("open_on_wrong", 32'(bus.open_btn), 0);
      check("locked_after_wrong", 32'(bus.locked), 32'(exp_locked));
      check("count_after_wrong", 32'(bus.digit_count), 0);
   endtask

   initial begin
      bus.digit               = 4'd0;
      bus.enter               = 1'b0;
      bus.door_cycle_complete = 1'b0;

      // Reset values
      step();
      check("rst_open_btn", 32'(bus.open_btn), 0);
      check("rst_locked", 32'(bus.locked), 0);
      check("rst_attempt_fail", 32'(bus.attempt_fail), 0);
      check("rst_digit_count", 32'(bus.digit_count), 0);
      check("rst_lock_remaining", 32'(bus.lock_remaining), 0);
      rst_a_p = 1'b0;
      step();

      // Correct code opens, door completion closes
      enter_code(16'h1234);
      expect_open_then_close();

      // Wrong code: one-cycle fail pulse, then correct code opens
      enter_code(16'h1235);
      expect_wrong(1'b0);
      step();
      check("attempt_fail_one_cycle", 32'(bus.attempt_fail), 0);
      enter_code(16'h1234);
      expect_open_then_close();

      // Three consecutive misses trigger lockout
      enter_code(16'h0000);
      expect_wrong(1'b0);
      enter_code(16'h4321);
      expect_wrong(1'b0);
      enter_code(16'h9999);
      expect_wrong(1'b1);
      check("lock_remaining_start", 32'(bus.lock_remaining), 20);
      for (int i = 1; i <= 20; i++) begin
         bus.digit = 4'd1;
         bus.enter = (i % 2 == 1);
         step();
         check("lock_remaining_dec", 32'(bus.lock_remaining), 32'(20 - i));
         check("locked_during", 32'(bus.locked), (i < 20) ? 1 : 0);
         check("count_in_lockout", 32'(bus.digit_count), 0);
      end
      bus.enter = 1'b0;
      enter_code(16'h1234);
      expect_open_then_close();

      // A success clears the fail counter
      enter_code(16'h1111);
      expect_wrong(1'b0);
      enter_code(16'h2222);
      expect_wrong(1'b0);
      enter_code(16'h1234);
      expect_open_then_close();
      enter_code(16'h3333);
      expect_wrong(1'b0);
      step();
      check("no_lockout_after_success", 32'(bus.locked), 0);

      // Enter held high across reset release is not a press
      rst_a_p   = 1'b1;
      bus.enter = 1'b1;
      bus.digit = 4'd7;
      step();
      rst_a_p = 1'b0;
      step();
      step();
      check("held_enter_no_capture", 32'(bus.digit_count), 0);
      bus.enter = 1'b0;
      step();
      check("held_enter_released", 32'(bus.digit_count), 0);
      bus.enter = 1'b1;
      step();
      check("fresh_press_captured", 32'(bus.digit_count), 1);
      bus.enter = 1'b0;
      step();

      // Reset while waiting on the door drops open_btn immediately
      rst_a_p = 1'b1;
      step();
      rst_a_p = 1'b0;
      step();
      enter_code(16'h1234);
      check("open_before_reset", 32'(bus.open_btn), 1);
      #2;
      rst_a_p = 1'b1;
      #1;
      check("async_reset_open_btn", 32'(bus.open_btn), 0);
      step();
      rst_a_p = 1'b0;
      bus.door_cycle_complete = 1'b1;
      step();
      bus.door_cycle_complete = 1'b0;
      check("dcc_after_reset_open", 32'(bus.open_btn), 0);
      check("dcc_after_reset_count", 32'(bus.digit_count), 0);
      check("dcc_after_reset_locked", 32'(bus.locked), 0);
      step();
      check("dcc_after_reset_open2", 32'(bus.open_btn), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
